// File: rtl/chip_select_arbiter.sv
// Round-robin arbiter driving an active-low decoder: one grant at a time, bounded hold,
// and a guaranteed dead cycle between grants. Every output comes from a register.
module chip_select_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 8,
  localparam int SEL_WIDTH = $clog2(WIDTH),
  localparam int CNT_WIDTH = $clog2(MAX_HOLD + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     req_n,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 en_n,
  output logic [WIDTH-1:0]     gnt_n,
  output logic                 busy,
  output logic                 timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t               state, state_next;
  logic [SEL_WIDTH-1:0] ptr, ptr_next;
  logic [SEL_WIDTH-1:0] sel_next;
  logic [CNT_WIDTH-1:0] hold_cnt, hold_next;
  logic                 timeout_next;

  logic [SEL_WIDTH-1:0] pick;
  logic [SEL_WIDTH-1:0] cand;
  logic                 found;
  logic                 release_now;
  logic                 at_limit;

  // Circular priority search starting at ptr; WIDTH is a power of two so the
  // index wraps by plain truncation.
  always_comb begin
    pick  = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      cand = ptr + SEL_WIDTH'(i);
      if (!found && !req_n[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign release_now = req_n[sel];
  assign at_limit    = (hold_cnt == CNT_WIDTH'(MAX_HOLD - 1));

  always_comb begin
    state_next   = state;
    sel_next     = sel;
    ptr_next     = ptr;
    hold_next    = hold_cnt;
    timeout_next = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (found) begin
          sel_next   = pick;
          hold_next  = '0;
          state_next = GRANT;
        end else begin
          state_next = IDLE;
        end
      end
      GRANT: begin
        if (hold_cnt != CNT_WIDTH'(MAX_HOLD))
          hold_next = hold_cnt + CNT_WIDTH'(1);
        if (release_now || at_limit) begin
          state_next   = GAP;
          ptr_next     = sel + SEL_WIDTH'(1);
          // A voluntary release on the limit cycle is not a timeout.
          timeout_next = !release_now;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      sel      <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      sel      <= sel_next;
      hold_cnt <= hold_next;
      timeout  <= timeout_next;
    end
  end

  assign busy = (state == GRANT);
  assign en_n = !busy;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gnt
    assign gnt_n[gi] = !(busy && (sel == SEL_WIDTH'(gi)));
  end

endmodule

// File: doc/chip_select_arbiter.md
CHIP_SELECT_ARBITER -- requirements
Module: chip_select_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the number of requesters and decoder outputs; it must be a power of two and at least 2.
REQ-002 The block SHALL have parameter MAX_HOLD, default 8, meaning the maximum consecutive grant cycles per requester; it must be at least 1.
REQ-003 The block SHALL derive localparam SEL_WIDTH = $clog2(WIDTH) and CNT_WIDTH = $clog2(MAX_HOLD+1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port req_n, input, WIDTH bits: active-low requests, one per requester.
REQ-007 The block SHALL have port sel, output, SEL_WIDTH bits: index of the granted requester, suited to drive a 2-to-4 decoder select input.
REQ-008 The block SHALL have port en_n, output, 1 bit: active-low decoder enable, low only while a grant is active.
REQ-009 The block SHALL have port gnt_n, output, WIDTH bits: active-low one-hot grant, equal to the decode of sel gated by en_n.
REQ-010 The block SHALL have port busy, output, 1 bit: high while in GRANT.
REQ-011 The block SHALL have port timeout, output, 1 bit: one-cycle pulse marking a forced release.

Function
REQ-012 The block SHALL implement a Moore FSM with states IDLE, GRANT and GAP; all outputs are decoded from registers only, with no combinational path from req_n to any output.
REQ-013 In IDLE and GAP, if any req_n bit is low, the block SHALL select the first low bit searching circularly from pointer ptr upward (ptr, ptr+1, ... mod WIDTH), load it into sel, clear hold_cnt to 0, and enter GRANT on the next edge.
REQ-014 In IDLE and GAP with all req_n high, the block SHALL go to IDLE and leave sel unchanged.
REQ-015 Grant latency SHALL be one cycle: a request sampled low at edge N drives gnt_n low from edge N onward, i.e. during cycle N+1.
REQ-016 In GRANT, the block SHALL increment hold_cnt each cycle, saturating at MAX_HOLD.
REQ-017 In GRANT, the block SHALL exit to GAP on the next edge if req_n[sel] is sampled high (normal release) or hold_cnt == MAX_HOLD-1 (forced release); a grant therefore lasts 1 to MAX_HOLD cycles.
REQ-018 If release and the hold limit coincide, the exit SHALL count as a normal release: timeout stays low.
REQ-019 On every exit from GRANT, the block SHALL set ptr = (sel+1) mod WIDTH, wrapping from WIDTH-1 to 0.
REQ-020 GAP SHALL last exactly one cycle with en_n=1, gnt_n all ones and busy=0, guaranteeing one dead cycle between any two grants, including a re-grant to the same requester.
REQ-021 timeout SHALL be high only during the GAP cycle that follows a forced release.
REQ-022 Requests from non-granted requesters during GRANT SHALL be ignored until GAP.
REQ-023 Changes of other req_n bits during GRANT SHALL NOT affect sel or hold_cnt.
REQ-024 Outside GRANT, en_n SHALL be 1 and gnt_n all ones.
REQ-025 In GRANT, gnt_n[sel] SHALL be 0 and all other gnt_n bits 1.

Reset
REQ-026 While rst is high, regardless of clk, the block SHALL hold state=IDLE, ptr=0, sel=0, hold_cnt=0, en_n=1, gnt_n all ones, busy=0 and timeout=0.
REQ-027 Reset asserted during GRANT SHALL deassert en_n and gnt_n immediately, without waiting for a clock edge.
REQ-028 After rst falls, the first arbitration SHALL start from ptr=0.

Verification
REQ-029 Single request: after reset, req_n=4'b1011 for 3 cycles, then 4'b1111 -> sel=2, gnt_n=4'b1011 for 3 cycles starting one cycle after the request; then one GAP cycle with timeout=0, then IDLE.
REQ-030 Round robin: req_n=4'b0000 held -> grants in order 0,1,2,3,0 with MAX_HOLD=8 cycles each, one dead cycle between grants, and timeout pulsing in each GAP.
REQ-031 Timeout: req_n[1] held low alone, MAX_HOLD=8 -> gnt_n[1] low for exactly 8 cycles, GAP with timeout=1, then re-grant to 1 after exactly one dead cycle.
REQ-032 Coincidence: req_n[0] released in the 8th grant cycle -> GAP with timeout=0.
REQ-033 Wrap: ptr=3, requests 0 and 2 active -> requester 0 is granted.
REQ-034 Async reset: rst pulsed mid-GRANT between clock edges -> en_n=1 and gnt_n=4'b1111 immediately; next grant after release starts search at 0.
